xor_selftest_seq: RTL and testbench

//  On-chip self-test sequencer for a combinational gate under test (the Xor part and other parity gates).
//  On start, drives every input vector 0..2^N_IN-1 onto the gate in order.

---
 rtl/xor_selftest_seq.sv | 83 ++++++++
 tb/tb_xor_selftest_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/xor_selftest_seq.sv
// Exhaustive self-test sequencer for a parity gate: sweeps every input vector,
// compares the sampled gate output with the expected parity and reports the result.
module xor_selftest_seq #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic [N_IN-1:0] first_fail_vec
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic          mismatch;

  assign mismatch = (dut_out != ^vec);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      settle_cnt     <= '0;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_vec <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state          <= S_SETTLE;
            busy           <= 1'b1;
            vec            <= '0;
            fail_count     <= '0;
            first_fail_vec <= '0;
            settle_cnt     <= CNT_INIT;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) state <= S_CHECK;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        S_CHECK: begin
          if (mismatch) begin
            fail_count <= fail_count + 1'b1;
            if (fail_count == '0) first_fail_vec <= vec;
          end
          // vec stays at all-ones after the last vector rather than wrapping
          if (vec == VEC_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            vec        <= vec + 1'b1;
            settle_cnt <= CNT_INIT;
            state      <= S_SETTLE;
          end
        end
        S_DONE: begin
          pass  <= (fail_count == '0);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_selftest_seq.sv
// Bench for xor_selftest_seq: two instances (SETTLE=1 and SETTLE=3) driven together,
// checked cycle by cycle against a timing/result model derived from the sweep rules.
module tb_xor_selftest_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  int         mode;
  logic [1:0] vec_a      [2];
  logic       dut_out_a  [2];
  logic       busy_a     [2];
  logic       done_a     [2];
  logic       pass_a     [2];
  logic [2:0] fc_a       [2];
  logic [1:0] ffv_a      [2];

  int tests = 0;
  int fails = 0;
  int dcount [2];

  always #5 clk = ~clk;

  // Gate under test: 0 good, 1 stuck-at-0, 2 inverted, 3 inverted only on vector 3
  function automatic logic gate(input logic [1:0] v, input int m);
    case (m)
      1:       return 1'b0;
      2:       return ~(^v);
      3:       return (v == 2'b11) ? ~(^v) : ^v;
      default: return ^v;
    endcase
  endfunction

  assign dut_out_a[0] = gate(vec_a[0], mode);
  assign dut_out_a[1] = gate(vec_a[1], mode);

  xor_selftest_seq #(.N_IN(2), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .vec(vec_a[0]), .dut_out(dut_out_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]), .fail_count(fc_a[0]),
    .first_fail_vec(ffv_a[0])
  );

  xor_selftest_seq #(.N_IN(2), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .vec(vec_a[1]), .dut_out(dut_out_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]), .fail_count(fc_a[1]),
    .first_fail_vec(ffv_a[1])
  );

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d: got %0h expected %0h", tag, i, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected results of a full sweep: count of vectors whose gate output differs from parity
  task automatic model_result(input int m, output int cnt, output int first);
    cnt   = 0;
    first = 0;
    for (int v = 0; v < 4; v++) begin
      if (int'(gate(2'(v), m)) != ($countones(v) % 2)) begin
        if (cnt == 0) first = v;
        cnt++;
      end
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // t = cycles since the cycle start was sampled
  task automatic check_cycle(input int t, input int m);
    int s, tot, ec, ef;
    for (int i = 0; i < 2; i++) begin
      s   = settle_of(i);
      tot = 4 * (s + 1);
      if (done_a[i] === 1'b1) dcount[i]++;
      if (t <= tot + 1) begin
        chk("busy", i, busy_a[i], t <= tot);
        chk("done", i, done_a[i], t == tot + 1);
        chk("vec",  i, vec_a[i],  (t <= tot) ? (t - 1) / (s + 1) : 3);
      end else if (t == tot + 2) begin
        model_result(m, ec, ef);
        chk("pass",       i, pass_a[i], ec == 0);
        chk("fail_count", i, fc_a[i],   ec);
        if (ec != 0) chk("first_fail_vec", i, ffv_a[i], ef);
        chk("busy_after", i, busy_a[i], 0);
      end
    end
  endtask

  // One full run of both instances; optionally re-pulse start in cycles 3 and 9
  task automatic run_check(input int m, input bit repulse);
    mode = m;
    dcount[0] = 0;
    dcount[1] = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= 19; t++) begin
      check_cycle(t, m);
      start = repulse && (t == 3 || t == 9);
      step();
    end
    start = 1'b0;
    chk("done_count", 0, dcount[0], 1);
    chk("done_count", 1, dcount[1], 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    mode  = 0;
    step();
    start = 1'b1;  // ignored during reset
    step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_vec",  i, vec_a[i],  0);
      chk("rst_busy", i, busy_a[i], 0);
      chk("rst_done", i, done_a[i], 0);
      chk("rst_pass", i, pass_a[i], 0);
      chk("rst_fc",   i, fc_a[i],   0);
      chk("rst_ffv",  i, ffv_a[i],  0);
    end
    start = 1'b0;
    reset = 1'b0;
    step();

    // directed sweeps: good, stuck-0, inverted, fault on last vector only
    run_check(0, 1'b0);
    run_check(1, 1'b0);
    run_check(2, 1'b0);
    run_check(3, 1'b0);
    run_check(0, 1'b0);

    // reset mid-run after a passing run: everything clears, no done appears
    mode = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t < 4; t++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("midrst_busy", i, busy_a[i], 0);
      chk("midrst_vec",  i, vec_a[i],  0);
      chk("midrst_fc",   i, fc_a[i],   0);
      chk("midrst_pass", i, pass_a[i], 0);
    end
    dcount[0] = 0;
    dcount[1] = 0;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 2; i++) if (done_a[i] === 1'b1) dcount[i]++;
      step();
    end
    chk("midrst_nodone", 0, dcount[0], 0);
    chk("midrst_nodone", 1, dcount[1], 0);
    chk("midrst_idle",   0, busy_a[0], 0);

    // start re-pulsed while busy / in DONE is ignored
    run_check(1, 1'b1);

    // start held high: next run accepted in the IDLE cycle after DONE
    mode = 0;
    start = 1'b1;
    step();
    for (int t = 1; t <= 20; t++) begin
      if (t == 10) chk("held_gap",   0, busy_a[0], 0);
      if (t == 11) chk("held_rerun", 0, busy_a[0], 1);
      if (t == 18) chk("held_gap",   1, busy_a[1], 0);
      if (t == 19) chk("held_rerun", 1, busy_a[1], 1);
      step();
    end
    start = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();

    // randomized fault modes, idle gaps and stray start pulses
    for (int r = 0; r < 8; r++) begin
      int gap;
      gap = int'($urandom_range(0, 4));
      for (int g = 0; g < gap; g++) step();
      run_check(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
